sec_key_reader: RTL
===================

SEC_KEY_READER -- requirements
Module: sec_key_reader

Interface
REQ-001 Parameter SEQ_LEN, default 4: number of unlock strobes issued before reading.
REQ-002 Parameter NBITS, default 16: number of serial bits read per transaction.
REQ-003 Parameter READ_NIB, default 4'h0: nibble driven on bus_ba_lo during read strobes.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  single-cycle request to begin a transaction.
REQ-007 abort  in  1  terminate the current transaction.
REQ-008 unlock_seq  in  4*SEQ_LEN  unlock nibbles; nibble i = bits [4i+3:4i], issued i=0 first.
REQ-009 sdrd  in  1  serial data returned by the key device while it is selected.
REQ-010 bus_sser  out  1  device select, active-low.
REQ-011 bus_ba13  out  1  address bit 13.
REQ-012 bus_ba12  out  1  address bit 12.
REQ-013 bus_ba_lo  out  4  address bits 7:4 (bit 3 = BA7).
REQ-014 bus_br_w  out  1  read strobe qualifier, 1 = read.
REQ-015 busy  out  1  transaction in progress.
REQ-016 data_out  out  NBITS  last completed word; holds until the next completion.
REQ-017 data_valid  out  1  one-cycle pulse when data_out updates.

Function
REQ-018 Bus idle value: bus_sser=1, bus_ba13=1, bus_ba12=0, bus_br_w=0, bus_ba_lo=0.
REQ-019 Strobe value: bus_sser=0, bus_ba13=0, bus_ba12=1, bus_br_w=1, with bus_ba_lo per phase; a strobe lasts exactly one cycle, because the device advances state on every selected clock edge.
REQ-020 Every strobe is followed by exactly one idle (gap) cycle; no two strobes are adjacent.
REQ-021 States: IDLE, UNLOCK_STB, UNLOCK_GAP, READ_STB, READ_GAP, DONE. All bus outputs are registered.
REQ-022 IDLE: start=1 and abort=0 sampled at cycle 0 -> UNLOCK_STB at cycle 1; unlock_seq is captured at cycle 0.
REQ-023 UNLOCK_STB i drives bus_ba_lo = captured nibble i; unlock strobes occur at cycles 1,3,...,2*SEQ_LEN-1.
REQ-024 After the gap following unlock strobe SEQ_LEN-1 -> READ_STB; read strobes drive READ_NIB at cycles 2*SEQ_LEN+1+2k, for k=0..NBITS-1.
REQ-025 sdrd is sampled at the end of each READ_STB cycle; read bit k goes to data_out bit k (LSB first) through an internal shift register; data_out stays unchanged during the transaction.
REQ-026 After the gap following the last read strobe -> DONE for one cycle: data_out loaded, data_valid=1, busy=0, then IDLE.
REQ-027 Latency: data_valid at cycle 1+2*SEQ_LEN+2*NBITS after start (41 at defaults).
REQ-028 busy=1 in all states other than IDLE and DONE (cycles 1..2*(SEQ_LEN+NBITS)).
REQ-029 start while busy or in DONE is ignored and not queued.
REQ-030 abort=1 in any busy state: the next cycle drives bus idle and enters IDLE; data_out is unchanged and there is no data_valid.
REQ-031 abort and start together in IDLE: abort wins and the block stays IDLE.
REQ-032 Counters are sized to hold SEQ_LEN-1 and NBITS-1 and wrap to 0 only on phase exit.

Reset
REQ-033 rst=1 at a clock edge -> IDLE, bus idle value, busy=0, data_valid=0, data_out=0, counters=0.
REQ-034 rst mid-transaction takes effect at the next edge and takes priority over start and abort; no further strobe is issued.

Verification
REQ-035 Defaults, unlock_seq=16'h3A59, sdrd model returns 16'hC35A LSB first -> bus_ba_lo strobes 9,5,A,3 at cycles 1,3,5,7; 16 read strobes with ba_lo=0; data_out=16'hC35A and data_valid at cycle 41.
REQ-036 Every cycle of a transaction: bus_sser=0 is never asserted on two consecutive cycles, and ba13/ba12/br_w take the strobe value only when sser=0.
REQ-037 Pulse start at cycle 10 of a busy transaction -> no effect; exactly 20 strobes total; single data_valid at cycle 41.
REQ-038 abort at cycle 12 -> cycle 13 bus idle, busy=0; data_out retains its prior value; no data_valid.
REQ-039 rst at cycle 20 together with start -> IDLE at cycle 21, all outputs at reset values; a fresh start afterwards completes normally.
REQ-040 Back-to-back: start in the DONE cycle is ignored; start the cycle after DONE -> first strobe on the next cycle.

Source files
------------

// File: rtl/sec_key_reader.sv
// Serial security-key reader: issues SEQ_LEN unlock strobes, then NBITS read
// strobes, each followed by one idle cycle, and assembles the returned bits LSB first.
module sec_key_reader #(
  parameter int          SEQ_LEN  = 4,
  parameter int          NBITS    = 16,
  parameter logic [3:0]  READ_NIB = 4'h0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [4*SEQ_LEN-1:0]   unlock_seq,
  input  logic                   sdrd,
  output logic                   bus_sser,
  output logic                   bus_ba13,
  output logic                   bus_ba12,
  output logic [3:0]             bus_ba_lo,
  output logic                   bus_br_w,
  output logic                   busy,
  output logic [NBITS-1:0]       data_out,
  output logic                   data_valid
);

  localparam int UW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int RW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [UW-1:0] U_LAST = UW'(SEQ_LEN - 1);
  localparam logic [RW-1:0] R_LAST = RW'(NBITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    UNLOCK_STB,
    UNLOCK_GAP,
    READ_STB,
    READ_GAP,
    DONE
  } state_t;

  state_t               r_state;
  state_t               w_nextState;
  logic [UW-1:0]        r_uCnt;
  logic [UW-1:0]        w_nextUCnt;
  logic [RW-1:0]        r_rCnt;
  logic [RW-1:0]        w_nextRCnt;
  logic [4*SEQ_LEN-1:0] r_seq;
  logic [4*SEQ_LEN-1:0] w_nibSrc;
  logic [NBITS-1:0]     r_shift;
  logic                 w_strobe;
  logic                 w_nextBusy;
  logic [3:0]           w_nextNib;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_uCnt  <= '0;
      r_rCnt  <= '0;
    end else begin
      r_state <= w_nextState;
      r_uCnt  <= w_nextUCnt;
      r_rCnt  <= w_nextRCnt;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextUCnt  = r_uCnt;
    w_nextRCnt  = r_rCnt;
    case (r_state)
      IDLE: begin
        if (start && !abort) begin
          w_nextState = UNLOCK_STB;
          w_nextUCnt  = '0;
          w_nextRCnt  = '0;
        end
      end
      UNLOCK_STB: w_nextState = UNLOCK_GAP;
      UNLOCK_GAP: begin
        if (r_uCnt == U_LAST) begin
          w_nextState = READ_STB;
          w_nextUCnt  = '0;
        end else begin
          w_nextState = UNLOCK_STB;
          w_nextUCnt  = r_uCnt + 1'b1;
        end
      end
      READ_STB: w_nextState = READ_GAP;
      READ_GAP: begin
        if (r_rCnt == R_LAST) begin
          w_nextState = DONE;
          w_nextRCnt  = '0;
        end else begin
          w_nextState = READ_STB;
          w_nextRCnt  = r_rCnt + 1'b1;
        end
      end
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase

    // Abort drops any busy phase straight back to idle; DONE/IDLE are unaffected.
    if (abort && (r_state != IDLE) && (r_state != DONE)) begin
      w_nextState = IDLE;
      w_nextUCnt  = '0;
      w_nextRCnt  = '0;
    end
  end

  // The first unlock nibble is issued before r_seq is loaded, so take it live.
  always_comb begin
    w_nibSrc   = (r_state == IDLE) ? unlock_seq : r_seq;
    w_strobe   = (w_nextState == UNLOCK_STB) || (w_nextState == READ_STB);
    w_nextBusy = (w_nextState != IDLE) && (w_nextState != DONE);
    w_nextNib  = 4'h0;
    if (w_nextState == UNLOCK_STB) begin
      w_nextNib = w_nibSrc[{w_nextUCnt, 2'b00} +: 4];
    end else if (w_nextState == READ_STB) begin
      w_nextNib = READ_NIB;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seq      <= '0;
      r_shift    <= '0;
      bus_sser   <= 1'b1;
      bus_ba13   <= 1'b1;
      bus_ba12   <= 1'b0;
      bus_br_w   <= 1'b0;
      bus_ba_lo  <= 4'h0;
      busy       <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      if ((r_state == IDLE) && (w_nextState == UNLOCK_STB)) begin
        r_seq <= unlock_seq;
      end
      if ((r_state == READ_STB) && (w_nextState == READ_GAP)) begin
        r_shift <= {sdrd, r_shift[NBITS-1:1]};
      end
      bus_sser   <= !w_strobe;
      bus_ba13   <= !w_strobe;
      bus_ba12   <= w_strobe;
      bus_br_w   <= w_strobe;
      bus_ba_lo  <= w_nextNib;
      busy       <= w_nextBusy;
      data_valid <= (w_nextState == DONE);
      if (w_nextState == DONE) begin
        data_out <= r_shift;
      end
    end
  end

endmodule
